spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Parametrised SPI master. Successor to the fixed mode-0, one-word, one-slave SPI driver.
- Adds all four CPOL/CPHA modes and a programmable SCLK divider.
- Adds multi-word bursts with chip select held low between words, multiple one-hot chip selects, and full-duplex MISO capture.
- Sits between a user-side valid/ready word stream and external SPI slave pins.

Parameters:
P_DATA_WIDTH, 8, bits per SPI word (MOSI and MISO), >=2
P_CPOL, 0, SCLK idle level
P_CPHA, 0, 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
P_CLK_DIV, 2, i_clk cycles per SCLK half-period, >=1
P_CS_NUM, 2, number of chip-select lines
P_CS_SEL_W, 1, width of i_cs_sel, equal to max(1, clog2(P_CS_NUM))

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_user_data  in  P_DATA_WIDTH  word to transmit, MSB first
i_user_valid  in  1  word offered
i_user_last  in  1  qualifies i_user_data: 1 = release CS after this word
i_cs_sel  in  P_CS_SEL_W  slave index, sampled only on the first word of a burst
o_ready  out  1  accepting a word; a word is accepted when i_user_valid & o_ready
o_user_data  out  P_DATA_WIDTH  received MISO word
o_user_valid  out  1  one-cycle pulse, o_user_data valid
o_busy  out  1  high whenever the state is not IDLE
o_spi_clk  out  1  SCLK
o_spi_mosi  out  1  MOSI
i_spi_miso  in  1  MISO, sampled directly with no synchroniser
o_cs  out  P_CS_NUM  active-low chip selects, at most one low at a time

Behaviour:
- Reset values: o_cs = all ones; o_spi_clk = P_CPOL; o_spi_mosi = 0; o_ready = 1; o_user_valid = 0; o_user_data = 0; o_busy = 0; state = IDLE.
- Reset asserted mid-transfer aborts immediately to the reset values. No o_user_valid pulse is produced.
- States: IDLE, SETUP, SHIFT, GAP, HOLD, RECOV.
- IDLE (o_ready = 1):
  - On accept: latch the data word, the last flag and i_cs_sel.
  - Drive o_cs[sel] low. If sel >= P_CS_NUM, no CS goes low, but the transfer still runs.
  - o_spi_mosi = data MSB. Go to SETUP.
- SETUP: wait P_CLK_DIV cycles with SCLK idle, then go to SHIFT.
- SHIFT:
  - A half-period counter runs 0..P_CLK_DIV-1. At the terminal count, SCLK toggles. This repeats for 2*P_DATA_WIDTH edges.
  - Odd-numbered edges (1,3,...) are leading edges; even-numbered edges are trailing edges.
  - P_CPHA=0: sample MISO on each leading edge. On each trailing edge except the last, drive the next MOSI bit.
  - P_CPHA=1: on each leading edge, drive MOSI (the MSB on edge 1). Sample MISO on each trailing edge.
  - MISO shifts into a receive register LSB-in, MSB-first.
  - After the final edge, SCLK equals P_CPOL. In the next cycle o_user_data = the received word and o_user_valid = 1 for exactly one cycle.
  - Then go to HOLD if last = 1, else to GAP.
- Total duration from accept to o_user_valid: P_CLK_DIV*(2*P_DATA_WIDTH+1)+1 cycles.
- GAP (o_ready = 1):
  - CS stays low and SCLK stays idle. Waits indefinitely.
  - On accept: latch data and last, ignore i_cs_sel, drive the MSB onto MOSI, go to SETUP.
- HOLD: P_CLK_DIV cycles with CS still low, then drive all CS high and go to RECOV.
- RECOV: P_CLK_DIV cycles with CS high, o_ready = 0, then go to IDLE. This guarantees minimum CS-high time.
- o_ready is 0 in SETUP, SHIFT, HOLD and RECOV. i_user_valid in those states is ignored and has no effect.
- o_ready is a registered output, asserted in the cycle the state enters IDLE or GAP.
- MOSI holds its last bit after the final edge until the next accept.
- The divider counter is reset on every entry to SETUP, HOLD and RECOV.

Test Plan:
- Mode 0, P_CLK_DIV=2, MISO looped to MOSI, send 0xA5 with last=1, sel=0:
  - o_cs=2'b10 for the whole transfer.
  - Exactly 8 rising SCLK edges.
  - o_user_data=0xA5 with a single o_user_valid pulse 35 cycles after accept.
  - CS high 2 cycles later.
  - o_ready back high 2 cycles after that.
- Mode 3, slave model returning 0x3C, send 0xC3 with sel=1:
  - SCLK idles high.
  - MOSI changes only on falling edges; the slave sees 0xC3.
  - o_cs=2'b01; o_user_data=0x3C.
- Burst of 3 words (0x11, 0x22, 0x33; last on the third), mode 1, i_cs_sel changed to 0 between words:
  - CS stays low continuously and stays on the first selection.
  - Three o_user_valid pulses.
  - CS rises only after the third word's HOLD.
- Burst stalled in GAP for 20 cycles:
  - CS stays low, SCLK stays idle, o_ready=1.
  - The next word transfers normally.
- i_user_valid held high during SHIFT with different data: no second accept and no corruption of the current word.
- i_rst_n pulsed low at the 5th SCLK edge:
  - All outputs return to reset values asynchronously and no o_user_valid pulse is produced.
  - The next transfer of 0x5A completes correctly.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// User-side word stream of the SPI master.
//   i_user_data/i_user_valid/i_user_last/i_cs_sel : word offered to the master
//   o_ready                                      : master accepts a word this cycle
//   o_user_data/o_user_valid                     : received MISO word, one-cycle pulse
//   o_busy                                       : master not idle
// Modport slave is the controller side, master is the user side.
interface spi_master_ctrl_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CS_SEL_W   = 1
);
  logic [P_DATA_WIDTH-1:0] i_user_data;
  logic                    i_user_valid;
  logic                    i_user_last;
  logic [P_CS_SEL_W-1:0]   i_cs_sel;
  logic                    o_ready;
  logic [P_DATA_WIDTH-1:0] o_user_data;
  logic                    o_user_valid;
  logic                    o_busy;

  modport slave (
    input  i_user_data, i_user_valid, i_user_last, i_cs_sel,
    output o_ready, o_user_data, o_user_valid, o_busy
  );

  modport master (
    output i_user_data, i_user_valid, i_user_last, i_cs_sel,
    input  o_ready, o_user_data, o_user_valid, o_busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: any CPOL/CPHA mode, programmable SCLK divider, multi-word
// bursts with CS held low between words, one-hot active-low chip selects
// and full-duplex MISO capture.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : user word stream (spi_master_ctrl_if.slave)
//   o_spi_clk      : SCLK
//   o_spi_mosi     : MOSI, MSB first
//   i_spi_miso     : MISO, sampled directly
//   o_cs           : active-low chip selects
module spi_master_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CPOL       = 0,
  parameter int P_CPHA       = 0,
  parameter int P_CLK_DIV    = 2,
  parameter int P_CS_NUM     = 2,
  parameter int P_CS_SEL_W   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  spi_master_ctrl_if.slave    bus,
  output logic                o_spi_clk,
  output logic                o_spi_mosi,
  input  logic                i_spi_miso,
  output logic [P_CS_NUM-1:0] o_cs
);

  localparam int CNT_W  = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2*P_DATA_WIDTH + 1);
  localparam bit SAMPLE_LEAD = (P_CPHA == 0);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, RECOV} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        div_cnt;
  logic [EDGE_W-1:0]       edge_cnt;
  logic [P_DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic                    last_q;
  logic [P_CS_SEL_W-1:0]   sel;
  logic [P_CS_NUM-1:0]     cs_dec;
  logic                    accept, div_tc, edges_done, sclk_edge, lead_edge;

  assign sel        = bus.i_cs_sel;
  assign accept     = bus.i_user_valid & bus.o_ready;
  assign div_tc     = (div_cnt == CNT_W'(P_CLK_DIV - 1));
  assign edges_done = (edge_cnt == EDGE_W'(2*P_DATA_WIDTH));
  assign sclk_edge  = (state == SHIFT) && div_tc && !edges_done;
  // Edge number edge_cnt+1 is odd (leading) when edge_cnt is even.
  assign lead_edge  = ~edge_cnt[0];
  assign bus.o_busy = (state != IDLE);

  // Out-of-range selections decode to no active line.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < P_CS_NUM; i++)
      if (int'(sel) == i) cs_dec[i] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, GAP: if (accept) state_nxt = SETUP;
      SETUP:     if (div_tc) state_nxt = SHIFT;
      SHIFT:     if (edges_done) state_nxt = last_q ? HOLD : GAP;
      HOLD:      if (div_tc) state_nxt = RECOV;
      RECOV:     if (div_tc) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt          <= '0;
      edge_cnt         <= '0;
      tx_sr            <= '0;
      rx_sr            <= '0;
      last_q           <= 1'b0;
      o_cs             <= '1;
      o_spi_clk        <= 1'(P_CPOL);
      o_spi_mosi       <= 1'b0;
      bus.o_ready      <= 1'b1;
      bus.o_user_valid <= 1'b0;
      bus.o_user_data  <= '0;
    end else begin
      bus.o_ready      <= (state_nxt == IDLE) || (state_nxt == GAP);
      bus.o_user_valid <= 1'b0;
      // Restart on every state change; free-run and wrap inside SHIFT.
      div_cnt <= (state_nxt != state || div_tc) ? '0 : div_cnt + CNT_W'(1);

      if (accept) begin
        // CPHA=0 already presents the MSB, so the next trailing edge needs bit MSB-1.
        tx_sr      <= SAMPLE_LEAD ? (bus.i_user_data << 1) : bus.i_user_data;
        o_spi_mosi <= bus.i_user_data[P_DATA_WIDTH-1];
        last_q     <= bus.i_user_last;
        if (state == IDLE) o_cs <= cs_dec;
      end

      if (state == SETUP) edge_cnt <= '0;

      if (sclk_edge) begin
        edge_cnt  <= edge_cnt + EDGE_W'(1);
        o_spi_clk <= ~o_spi_clk;
        if (lead_edge == SAMPLE_LEAD)
          rx_sr <= {rx_sr[P_DATA_WIDTH-2:0], i_spi_miso};
        else if (!SAMPLE_LEAD || edge_cnt != EDGE_W'(2*P_DATA_WIDTH - 1)) begin
          // The final trailing edge of a CPHA=0 word leaves MOSI on its last bit.
          o_spi_mosi <= tx_sr[P_DATA_WIDTH-1];
          tx_sr      <= tx_sr << 1;
        end
      end

      if (state == SHIFT && edges_done) begin
        bus.o_user_valid <= 1'b1;
        bus.o_user_data  <= rx_sr;
      end

      if (state == HOLD && div_tc) o_cs <= '1;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Runs all four SPI modes side by side on identical user stimulus. Each
// instance talks to a behavioural SPI slave that records the MOSI word it
// sees and returns a word from reply_tab.
module tb_spi_master_ctrl;
  localparam int DW  = 8;
  localparam int DIV = 2;
  localparam int LAT = DIV*(2*DW + 1) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] t_data;
  logic          t_valid, t_last, t_sel;
  logic [DW-1:0] reply_tab [0:3];
  logic [1:0]    exp_cs;

  logic [3:0]         rdy, uv, busy, sclk, mosi;
  logic [3:0][DW-1:0] rdata, seen;
  logic [3:0][1:0]    cs;
  logic [3:0][15:0]   rise_v, tog_v, nseen_v, nbad_v, nuv_v;

  for (genvar m = 0; m < 4; m++) begin : g
    localparam int CPOL = m / 2;
    localparam int CPHA = m % 2;

    spi_master_ctrl_if #(.P_DATA_WIDTH(DW), .P_CS_SEL_W(1)) bus ();
    logic       sck, mo;
    logic       mi = 1'b0;
    logic [1:0] csn;

    spi_master_ctrl #(
      .P_DATA_WIDTH(DW), .P_CPOL(CPOL), .P_CPHA(CPHA),
      .P_CLK_DIV(DIV), .P_CS_NUM(2), .P_CS_SEL_W(1)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
      .o_spi_clk(sck), .o_spi_mosi(mo), .i_spi_miso(mi), .o_cs(csn)
    );

    assign bus.i_user_data  = t_data;
    assign bus.i_user_valid = t_valid;
    assign bus.i_user_last  = t_last;
    assign bus.i_cs_sel     = t_sel;
    assign rdy[m]   = bus.o_ready;
    assign uv[m]    = bus.o_user_valid;
    assign busy[m]  = bus.o_busy;
    assign rdata[m] = bus.o_user_data;
    assign sclk[m]  = sck;
    assign mosi[m]  = mo;
    assign cs[m]    = csn;

    // Slave: selected while any CS is low; drives on shift edges, samples on the others.
    logic          sel_any;
    logic          p_sel = 1'b0;
    logic          p_sck = 1'(CPOL);
    logic [DW-1:0] ssr = '0, srx = '0, slast = '0;
    int            bitn = 0, wn = 0;
    logic [15:0]   nrise = '0, ntog = '0, nseen = '0, nbad = '0, nuv = '0;
    assign sel_any = (csn != 2'b11);

    always @(sel_any, sck) begin
      if (sck !== p_sck) begin
        ntog++;
        if (sck === 1'b1) nrise++;
      end
      if (sel_any !== p_sel) begin
        bitn = 0;
        wn   = 0;
        if (sel_any && CPHA == 0) begin
          ssr = reply_tab[0];
          mi  = ssr[DW-1];
          ssr = ssr << 1;
        end
      end else if (sck !== p_sck && sel_any) begin
        if (csn !== exp_cs) nbad++;
        if ((sck != 1'(CPOL)) == (CPHA == 0)) begin
          srx = {srx[DW-2:0], mo};
          bitn++;
          if (bitn == DW) begin
            slast = srx;
            nseen++;
            bitn = 0;
            wn++;
          end
        end else begin
          if (bitn == 0) ssr = reply_tab[wn % 4];
          mi  = ssr[DW-1];
          ssr = ssr << 1;
        end
      end
      p_sel = sel_any;
      p_sck = sck;
    end

    always @(posedge clk) if (bus.o_user_valid) nuv <= nuv + 16'd1;

    assign seen[m]    = slast;
    assign rise_v[m]  = nrise;
    assign tog_v[m]   = ntog;
    assign nseen_v[m] = nseen;
    assign nbad_v[m]  = nbad;
    assign nuv_v[m]   = nuv;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[mode%0d]: observed 0x%0h expected 0x%0h", tag, m, obs, exp);
    end
  endtask

  function automatic logic cpol_of(input int m);
    return 1'(m / 2);
  endfunction

  task automatic check_reset(input string tag);
    for (int m = 0; m < 4; m++) begin
      chk({tag, "_cs"},    m, 32'(cs[m]),    32'h3);
      chk({tag, "_sclk"},  m, 32'(sclk[m]),  32'(cpol_of(m)));
      chk({tag, "_mosi"},  m, 32'(mosi[m]),  0);
      chk({tag, "_ready"}, m, 32'(rdy[m]),   1);
      chk({tag, "_uv"},    m, 32'(uv[m]),    0);
      chk({tag, "_rdata"}, m, 32'(rdata[m]), 0);
      chk({tag, "_busy"},  m, 32'(busy[m]),  0);
    end
  endtask

  // One word through all four instances; rep is the word the slaves return.
  task automatic send(input logic [DW-1:0] w, input logic lst, input logic s,
                      input logic hold, input logic [DW-1:0] rep);
    int n, acc;
    logic [3:0][15:0] rise0, seen0;
    n = 0;
    while (!rdy[0] && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", 0, 32'(rdy[0]), 1);
    rise0 = rise_v;
    seen0 = nseen_v;
    t_data = w; t_last = lst; t_sel = s; t_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    for (int m = 0; m < 4; m++) begin
      chk("acc_ready", m, 32'(rdy[m]),  0);
      chk("acc_busy",  m, 32'(busy[m]), 1);
      chk("acc_mosi",  m, 32'(mosi[m]), 32'(w[DW-1]));
    end
    if (hold) begin
      t_data = ~w; t_sel = ~s; t_last = ~lst;
    end else begin
      t_valid = 1'b0; t_data = DW'($urandom); t_last = 1'($urandom); t_sel = 1'($urandom);
    end
    while (!uv[0] && (cyc - acc) < LAT + 20) begin
      @(negedge clk);
      if (hold && (cyc - acc) == 30) t_valid = 1'b0;
    end
    chk("latency", 0, 32'(cyc - acc), LAT);
    for (int m = 0; m < 4; m++) begin
      chk("uv",        m, 32'(uv[m]),               1);
      chk("rx_word",   m, 32'(rdata[m]),            32'(rep));
      chk("slave_saw", m, 32'(seen[m]),             32'(w));
      chk("sclk_rise", m, 32'(rise_v[m] - rise0[m]), DW);
      chk("word_cnt",  m, 32'(nseen_v[m] - seen0[m]), 1);
      chk("cs_edges",  m, 32'(nbad_v[m]),           0);
      chk("cs_done",   m, 32'(cs[m]),               32'(exp_cs));
      chk("sclk_idle", m, 32'(sclk[m]),             32'(cpol_of(m)));
      chk("ready_gap", m, 32'(rdy[m]),              32'(!lst));
    end
    @(negedge clk);
    for (int m = 0; m < 4; m++) chk("uv_pulse", m, 32'(uv[m]), 0);
    if (lst) begin
      for (int m = 0; m < 4; m++) chk("hold_cs", m, 32'(cs[m]), 32'(exp_cs));
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        chk("cs_release", m, 32'(cs[m]), 32'h3);
        chk("recov_rdy",  m, 32'(rdy[m]), 0);
      end
      @(negedge clk);
      for (int m = 0; m < 4; m++) chk("recov_rdy2", m, 32'(rdy[m]), 0);
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        chk("idle_rdy",  m, 32'(rdy[m]),  1);
        chk("idle_busy", m, 32'(busy[m]), 0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] w, r;
    logic s;
    int n;
    logic [15:0] tog0;
    logic [3:0][15:0] uv0;

    rst_n = 1'b0; t_valid = 1'b0; t_data = '0; t_last = 1'b0; t_sel = 1'b0;
    exp_cs = 2'b11;
    for (int i = 0; i < 4; i++) reply_tab[i] = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_reset");

    // Single word, CS0; the reply equals the transmitted word as with a loopback.
    exp_cs = 2'b10; reply_tab[0] = 8'hA5;
    send(8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5);

    // Single word, CS1, slave answers 0x3C.
    exp_cs = 2'b01; reply_tab[0] = 8'h3C;
    send(8'hC3, 1'b1, 1'b1, 1'b0, 8'h3C);

    // Three-word burst on CS1; the selection changes to 0 after the first word.
    exp_cs = 2'b01;
    for (int i = 0; i < 3; i++) reply_tab[i] = DW'($urandom);
    send(8'h11, 1'b0, 1'b1, 1'b0, reply_tab[0]);
    repeat (20) begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        chk("gap_cs",    m, 32'(cs[m]),   32'(exp_cs));
        chk("gap_sclk",  m, 32'(sclk[m]), 32'(cpol_of(m)));
        chk("gap_ready", m, 32'(rdy[m]),  1);
      end
    end
    send(8'h22, 1'b0, 1'b0, 1'b0, reply_tab[1]);
    send(8'h33, 1'b1, 1'b0, 1'b0, reply_tab[2]);

    // Random single words; the first keeps i_user_valid high through SHIFT.
    for (int k = 0; k < 4; k++) begin
      w = DW'($urandom); r = DW'($urandom); s = 1'($urandom_range(0, 1));
      exp_cs = s ? 2'b01 : 2'b10;
      reply_tab[0] = r;
      send(w, 1'b1, s, k == 0, r);
    end

    // Reset pulse at the fifth SCLK edge of a transfer.
    exp_cs = 2'b10; reply_tab[0] = DW'($urandom);
    uv0 = nuv_v;
    tog0 = tog_v[0];
    t_data = 8'h96; t_last = 1'b1; t_sel = 1'b0; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    n = 0;
    while ((tog_v[0] - tog0) < 16'd5 && n < 200) begin @(posedge clk); #1; n++; end
    chk("edge5_reached", 0, 32'(tog_v[0] - tog0), 5);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    for (int m = 0; m < 4; m++) chk("no_uv_after_abort", m, 32'(nuv_v[m] - uv0[m]), 0);

    exp_cs = 2'b10; r = DW'($urandom); reply_tab[0] = r;
    send(8'h5A, 1'b1, 1'b0, 1'b0, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
